// File: rtl/psmac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : psmac_pkg
//  Description : Shared types, default widths and saturation-limit helpers
//                for the precision-scalable MAC accumulator family.
//  Revision    : 1.0 - initial release
// ============================================================================
package psmac_pkg;

  // Default widths: product input, accumulator/result, term count
  localparam int IN_W_DEF  = 16;
  localparam int ACC_W_DEF = 32;
  localparam int LEN_W_DEF = 10;

  // Job sequencing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Largest signed value representable in acc_w bits, as a 64-bit pattern.
  // Callers keep the low acc_w bits.
  function automatic logic [63:0] sat_max(input int acc_w);
    return (64'd1 << (acc_w - 1)) - 64'd1;
  endfunction

  // Smallest signed value representable in acc_w bits. The low acc_w bits
  // of the complement of the maximum are 1000...0.
  function automatic logic [63:0] sat_min(input int acc_w);
    return ~sat_max(acc_w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/psmac_sat_add.sv
`default_nettype none
// ============================================================================
//  Module      : psmac_sat_add
//  Description : Combinational signed saturating adder. Adds a sign-extended
//                IN_W operand to an ACC_W accumulator at ACC_W+1 bits and
//                clamps to the ACC_W signed range, flagging any clamp.
//  Revision    : 1.0 - initial release
// ============================================================================
module psmac_sat_add
  import psmac_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic signed [IN_W-1:0]  addend,
  output logic signed [ACC_W-1:0] sum,
  output logic                    ovf
);

  localparam logic [63:0]      c_max64 = sat_max(ACC_W);
  localparam logic [63:0]      c_min64 = sat_min(ACC_W);
  localparam logic [ACC_W-1:0] c_max   = c_max64[ACC_W-1:0];
  localparam logic [ACC_W-1:0] c_min   = c_min64[ACC_W-1:0];

  logic signed [ACC_W:0] w_acc_ext;
  logic signed [ACC_W:0] w_add_ext;
  logic signed [ACC_W:0] w_wide;

  // One guard bit on both operands so the true sum is always representable
  assign w_acc_ext = {acc[ACC_W-1], acc};
  assign w_add_ext = {{(ACC_W + 1 - IN_W){addend[IN_W-1]}}, addend};
  assign w_wide    = w_acc_ext + w_add_ext;

  // Guard bit disagreeing with the ACC_W sign bit means the result left the
  // ACC_W range; the guard bit tells which side it left on.
  always_comb begin
    sum = w_wide[ACC_W-1:0];
    ovf = 1'b0;
    if (w_wide[ACC_W] != w_wide[ACC_W-1]) begin
      ovf = 1'b1;
      sum = w_wide[ACC_W] ? c_min : c_max;
    end
  end

endmodule
`default_nettype wire

// File: rtl/psmac_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : psmac_accumulator
//  Description : Accumulates a programmable number of signed products from
//                the precision-scalable multiplier into one saturated
//                dot-product result, delivered on a valid/ready port with a
//                sticky saturation flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module psmac_accumulator
  import psmac_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  in_data,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic signed [ACC_W-1:0] out_data,
  output logic                    out_sat,
  input  logic                    out_ready,
  output logic                    busy
);

  localparam logic [LEN_W-1:0] c_one = LEN_W'(1);

  state_t                   r_state;
  logic signed [ACC_W-1:0]  r_acc;
  logic [LEN_W-1:0]         r_cnt;
  logic [LEN_W-1:0]         r_len;
  logic                     r_sat;

  state_t                   w_state_nxt;
  logic signed [ACC_W-1:0]  w_acc_nxt;
  logic [LEN_W-1:0]         w_cnt_nxt;
  logic [LEN_W-1:0]         w_len_nxt;
  logic                     w_sat_nxt;
  logic                     w_launch;
  logic signed [ACC_W-1:0]  w_sum;
  logic                     w_ovf;

  psmac_sat_add #(
    .IN_W  (IN_W),
    .ACC_W (ACC_W)
  ) u_sat_add (
    .acc    (r_acc),
    .addend (in_data),
    .sum    (w_sum),
    .ovf    (w_ovf)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Accumulator, term counter, latched length and sticky saturation flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_len <= '0;
      r_sat <= 1'b0;
    end else begin
      r_acc <= w_acc_nxt;
      r_cnt <= w_cnt_nxt;
      r_len <= w_len_nxt;
      r_sat <= w_sat_nxt;
    end
  end

  // Next-state and datapath update; a job launch from IDLE or from the DONE
  // handshake shares one path, and clr overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len;
    w_sat_nxt   = r_sat;
    w_launch    = 1'b0;

    case (r_state)
      IDLE: begin
        w_launch = start;
      end
      ACCUM: begin
        // in_ready is high throughout ACCUM, so in_valid alone accepts
        if (in_valid) begin
          w_acc_nxt = w_sum;
          w_sat_nxt = r_sat | w_ovf;
          w_cnt_nxt = r_cnt + c_one;
          if (r_cnt == (r_len - c_one)) begin
            w_state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
          w_launch    = start;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    if (w_launch) begin
      w_acc_nxt = '0;
      w_cnt_nxt = '0;
      w_sat_nxt = 1'b0;
      if (len != '0) begin
        w_len_nxt   = len;
        w_state_nxt = ACCUM;
      end else begin
        // Empty job: the zero accumulator is the result
        w_state_nxt = DONE;
      end
    end

    if (clr) begin
      w_state_nxt = IDLE;
      w_acc_nxt   = '0;
      w_cnt_nxt   = '0;
      w_sat_nxt   = 1'b0;
    end
  end

  // Outputs decode only registered state, so nothing on in_data reaches them
  assign in_ready  = (r_state == ACCUM);
  assign out_valid = (r_state == DONE);
  assign out_data  = (r_state == DONE) ? r_acc : '0;
  assign out_sat   = (r_state == DONE) ? r_sat : 1'b0;
  assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_psmac_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_psmac_accumulator
//  Description : Directed self-checking bench for psmac_accumulator with a
//                result scoreboard, run with an 18-bit accumulator so the
//                saturation limits are reachable.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_psmac_accumulator;

  localparam int IN_W  = 16;
  localparam int ACC_W = 18;
  localparam int LEN_W = 10;

  typedef struct {
    logic signed [ACC_W-1:0] d;
    logic                    s;
  } exp_t;

  logic                    clk;
  logic                    rst_n;
  logic                    clr;
  logic                    start;
  logic [LEN_W-1:0]        len;
  logic                    in_valid;
  logic signed [IN_W-1:0]  in_data;
  logic                    in_ready;
  logic                    out_valid;
  logic signed [ACC_W-1:0] out_data;
  logic                    out_sat;
  logic                    out_ready;
  logic                    busy;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  exp_t mon_e;

  psmac_accumulator #(
    .IN_W  (IN_W),
    .ACC_W (ACC_W),
    .LEN_W (LEN_W)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic term(input logic signed [IN_W-1:0] v);
    in_valid = 1'b1;
    in_data  = v;
    step();
  endtask

  task automatic push_exp(input int d, input logic s);
    exp_t e;
    e.d = ACC_W'(d);
    e.s = s;
    sb.push_back(e);
  endtask

  // Results are scored on the cycle a handshake is about to complete
  always @(negedge clk) begin
    if (rst_n && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected: observed result=%0d expected=no result", out_data);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("sb_data", out_data, mon_e.d);
        chk("sb_sat", out_sat, mon_e.s);
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    clr       = 1'b0;
    start     = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset held: everything reads zero
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    rst_n = 1'b1;
    step();
    chk("rel_busy", busy, 0);
    chk("rel_out_valid", out_valid, 0);
    chk("rel_in_ready", in_ready, 0);

    // Basic job: 100 - 50 + 7 - 3 = 54
    out_ready = 1'b1;
    start     = 1'b1;
    len       = 10'd4;
    push_exp(54, 1'b0);
    step();
    start = 1'b0;
    chk("basic_busy", busy, 1);
    chk("basic_in_ready", in_ready, 1);
    term(100);
    term(-50);
    term(7);
    chk("basic_not_early", out_valid, 0);
    term(-3);
    in_valid = 1'b0;
    chk("basic_valid", out_valid, 1);
    chk("basic_data", out_data, 54);
    chk("basic_in_ready_done", in_ready, 0);
    step();
    chk("basic_busy_fall", busy, 0);
    chk("basic_valid_fall", out_valid, 0);

    // Positive saturation: 8 * 32767 exceeds 2^17-1
    start = 1'b1;
    len   = 10'd8;
    push_exp(131071, 1'b1);
    step();
    start = 1'b0;
    repeat (8) term(32767);
    in_valid = 1'b0;
    chk("satp_valid", out_valid, 1);
    chk("satp_sat", out_sat, 1);
    step();

    // Negative saturation: 8 * -32768 is below -2^17
    start = 1'b1;
    len   = 10'd8;
    push_exp(-131072, 1'b1);
    step();
    start = 1'b0;
    repeat (8) term(-32768);
    in_valid = 1'b0;
    chk("satn_valid", out_valid, 1);
    chk("satn_data", out_data, -131072);
    step();

    // Back-pressure: result 11 held while extra terms and starts are ignored
    out_ready = 1'b0;
    start     = 1'b1;
    len       = 10'd2;
    push_exp(11, 1'b0);
    step();
    start = 1'b0;
    term(5);
    term(6);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 99;
      start    = 1'b1;
      len      = 10'd3;
      step();
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, 11);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;

    // Back-to-back: start on the handshake cycle, terms with bubbles
    out_ready = 1'b1;
    start     = 1'b1;
    len       = 10'd3;
    push_exp(6, 1'b0);
    step();
    start = 1'b0;
    chk("b2b_in_ready", in_ready, 1);
    chk("b2b_valid_low", out_valid, 0);
    term(1);
    in_valid = 1'b0;
    step();
    term(2);
    in_valid = 1'b0;
    step();
    step();
    chk("b2b_wait", out_valid, 0);
    term(3);
    in_valid = 1'b0;
    chk("b2b_latency", out_valid, 1);
    chk("b2b_data", out_data, 6);
    step();
    chk("b2b_idle", busy, 0);

    // Zero length: result of 0 on the next cycle
    start = 1'b1;
    len   = 10'd0;
    push_exp(0, 1'b0);
    step();
    start = 1'b0;
    chk("zl_valid", out_valid, 1);
    chk("zl_data", out_data, 0);
    chk("zl_sat", out_sat, 0);
    chk("zl_in_ready", in_ready, 0);
    step();
    chk("zl_idle", busy, 0);

    // Asynchronous reset mid-accumulation, observed before the next edge
    start = 1'b1;
    len   = 10'd4;
    step();
    start = 1'b0;
    term(10);
    term(20);
    in_valid = 1'b0;
    chk("arst_pre_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("arst_after", busy, 0);

    // clr in DONE drops the pending result
    out_ready = 1'b0;
    start     = 1'b1;
    len       = 10'd1;
    step();
    start = 1'b0;
    term(9);
    in_valid = 1'b0;
    chk("clr_pre_valid", out_valid, 1);
    chk("clr_pre_data", out_data, 9);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_valid", out_valid, 0);
    chk("clr_busy", busy, 0);
    out_ready = 1'b1;
    step();
    chk("clr_stays_idle", out_valid, 0);

    // Fresh job after abort
    start = 1'b1;
    len   = 10'd1;
    push_exp(-7, 1'b0);
    step();
    start = 1'b0;
    term(-7);
    in_valid = 1'b0;
    chk("new_valid", out_valid, 1);
    chk("new_data", out_data, -7);
    step();
    step();

    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
